// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the back-end stall/flush controller.
// Stage indices, pause vector type, FSM states and the stall encoder.
package pipeline_ctrl_pkg;

  localparam int PAUSE_W = 6;

  localparam int PC_STG  = 0;
  localparam int IF_STG  = 1;
  localparam int ID_STG  = 2;
  localparam int EX_STG  = 3;
  localparam int MEM_STG = 4;
  localparam int WB_STG  = 5;

  typedef logic [PAUSE_W-1:0] pause_t;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    FLUSH
  } ctrl_state_t;

  typedef struct packed {
    logic mem;
    logic exec;
    logic decode;
    logic fetch;
  } stall_req_t;

  function automatic pause_t upto(input int k);
    pause_t m;
    for (int i = 0; i < PAUSE_W; i++) begin
      m[i] = (i <= k);
    end
    return m;
  endfunction

  // Simultaneous requests are legal, so the oldest stage takes priority.
  function automatic pause_t encode_pause(input stall_req_t r);
    pause_t p;
    priority case (1'b1)
      r.mem:    p = upto(MEM_STG);
      r.exec:   p = upto(EX_STG);
      r.decode: p = upto(ID_STG);
      r.fetch:  p = upto(IF_STG);
      default:  p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bundle between the pipeline stages and the controller.
// master: pipeline side raising requests; slave: the controller.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);

  logic              stall_req_if;
  logic              stall_req_id;
  logic              stall_req_ex;
  logic              stall_req_mem;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_pc;
  pause_t            pause;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic [CNT_W-1:0]  stall_cnt;
  logic              hang_err;

  modport master (
    output stall_req_if,
    output stall_req_id,
    output stall_req_ex,
    output stall_req_mem,
    output flush_req,
    output flush_pc,
    input  pause,
    input  flush,
    input  new_pc,
    input  stall_cnt,
    input  hang_err
  );

  modport slave (
    input  stall_req_if,
    input  stall_req_id,
    input  stall_req_ex,
    input  stall_req_mem,
    input  flush_req,
    input  flush_pc,
    output pause,
    output flush,
    output new_pc,
    output stall_cnt,
    output hang_err
  );

endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive MEM stall cycles; raises a sticky hang flag
// once the run length reaches TIMEOUT.
module pipeline_ctrl_stall_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic hang_err
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      hang_err <= 1'b0;
    end else begin
      if (!stall) begin
        cnt <= '0;
      end else if (cnt != W'(TIMEOUT)) begin
        cnt <= cnt + W'(1);
      end
      if (stall && cnt == W'(TIMEOUT - 1)) begin
        hang_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Back-end stall/flush controller: stall encoder, redirect FSM,
// saturating stall-cycle counter and MEM-stall watchdog.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1023
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  ctrl_state_t       state;
  logic              flush_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hang_q;
  stall_req_t        req;
  pause_t            enc;
  pause_t            pause_d;

  assign req = '{
    mem:    bus.stall_req_mem,
    exec:   bus.stall_req_ex,
    decode: bus.stall_req_id,
    fetch:  bus.stall_req_if
  };

  // PEND freezes everything younger than MEM behind the redirect.
  always_comb begin
    enc     = encode_pause(req);
    pause_d = enc;
    unique case (state)
      RUN:     pause_d = enc;
      PEND:    pause_d = enc | upto(EX_STG);
      FLUSH:   pause_d = '0;
      default: pause_d = enc;
    endcase
    pause_d[WB_STG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      flush_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      flush_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.flush_req) begin
            pc_q <= bus.flush_pc;
            if (!bus.stall_req_mem) begin
              state   <= FLUSH;
              flush_q <= 1'b1;
            end else begin
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (!bus.stall_req_mem) begin
            state   <= FLUSH;
            flush_q <= 1'b1;
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pause_d[PC_STG] && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  pipeline_ctrl_stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.stall_req_mem),
    .hang_err (hang_q)
  );

  assign bus.pause     = pause_d;
  assign bus.flush     = flush_q;
  assign bus.new_pc    = pc_q;
  assign bus.stall_cnt = cnt_q;
  assign bus.hang_err  = hang_q;

endmodule
